// File: rtl/cnu_min_sched_if.sv
// Control/strobe bundle between the decoder FSM, the row scheduler and the CNU datapath.
interface cnu_min_sched_if #(
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned ITER_W = 5
);
    logic              start;
    logic [ITER_W-1:0] iters;
    logic              hold;
    logic              abort;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ROW_W-1:0]  rd_addr;
    logic              cmp_en;
    logic              res_valid;
    logic [ROW_W-1:0]  res_row;
    logic [ITER_W-1:0] res_iter;

    // Decoder-side view: launches runs and consumes strobes/tags
    modport master (
        output start, iters, hold, abort,
        input  busy, done, rd_en, rd_addr, cmp_en, res_valid, res_row, res_iter
    );

    // Scheduler-side view
    modport slave (
        input  start, iters, hold, abort,
        output busy, done, rd_en, rd_addr, cmp_en, res_valid, res_row, res_iter
    );
endinterface

// File: rtl/cnu_min_sched.sv
// Check-node min-finder row scheduler: issues one message-RAM row read per cycle,
// strobes the finder when the row data lands and tags each result with row/pass.
module cnu_min_sched #(
    parameter int unsigned ROWS   = 12,
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned ITER_W = 5,
    parameter int unsigned RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    cnu_min_sched_if.slave bus
);
    // Stage 0 is the issue register (rd_en), stage RD_LAT feeds cmp_en,
    // stage RD_LAT+1 lines up with the finder's output register.
    localparam int unsigned       DEPTH    = RD_LAT + 2;
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] iter_last;
    logic              busy_q;
    logic              done_q;

    logic [DEPTH-1:0]  pv;
    logic [ROW_W-1:0]  pr [DEPTH];
    logic [ITER_W-1:0] pi [DEPTH];

    logic issue_c;
    logic last_row_c;
    logic final_c;
    logic empty_c;

    // Issue decision and drain-complete detection
    always_comb begin
        issue_c    = (state == S_RUN) && !bus.hold;
        last_row_c = (row == ROW_LAST);
        final_c    = issue_c && last_row_c && (iter == iter_last);
        // Result stage is excluded: it empties on the same edge DONE is entered
        empty_c    = ~|pv[RD_LAT:0];
    end

    // Sequencer FSM, row/pass counters and tag pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            row       <= '0;
            iter      <= '0;
            iter_last <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pv        <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pr[k] <= '0;
                pi[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            // Tags advance every cycle, hold only stops new entries
            for (int unsigned k = 1; k < DEPTH; k++) begin
                pv[k] <= pv[k-1];
                pr[k] <= pr[k-1];
                pi[k] <= pi[k-1];
            end
            pv[0] <= issue_c;
            if (issue_c) begin
                pr[0] <= row;
                pi[0] <= iter;
            end

            if (bus.abort) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                pv     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            state     <= S_RUN;
                            busy_q    <= 1'b1;
                            row       <= '0;
                            iter      <= '0;
                            // A request for zero passes runs a single pass
                            iter_last <= (bus.iters == '0) ? '0 : bus.iters - ITER_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (issue_c) begin
                            if (final_c) begin
                                state <= S_DRAIN;
                            end
                            if (last_row_c) begin
                                row  <= '0;
                                iter <= iter + ITER_W'(1);
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (empty_c) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // All outputs come straight from registers
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = pv[0];
    assign bus.rd_addr   = pr[0];
    assign bus.cmp_en    = pv[RD_LAT];
    assign bus.res_valid = pv[RD_LAT+1];
    assign bus.res_row   = pr[RD_LAT+1];
    assign bus.res_iter  = pi[RD_LAT+1];
endmodule

// File: tb/tb_cnu_min_sched.sv
// Bench for cnu_min_sched: two instances (RD_LAT=1/ROWS=4 and RD_LAT=3/ROWS=5)
// checked every cycle against an issue-log reference model, plus directed sequences.
module tb_cnu_min_sched;
    localparam int ROWS_A = 4;
    localparam int LAT_A  = 1;
    localparam int ROWS_B = 5;
    localparam int LAT_B  = 3;
    localparam int HIST   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 32;

    cnu_min_sched_if #(.ROW_W(4), .ITER_W(5)) ifa ();
    cnu_min_sched_if #(.ROW_W(4), .ITER_W(5)) ifb ();

    cnu_min_sched #(.ROWS(ROWS_A), .ROW_W(4), .ITER_W(5), .RD_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    cnu_min_sched #(.ROWS(ROWS_B), .ROW_W(4), .ITER_W(5), .RD_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: run phase + a log of issued reads indexed by cycle.
    // An output seen L cycles after an issue is valid unless the log was wiped.
    int m_ph [2];   // 0 idle, 1 run, 2 drain, 3 done
    int m_row[2];
    int m_it [2];
    int m_itn[2];
    int m_dat[2];
    bit m_done[2];
    bit hv [2][HIST];
    int hr [2][HIST];
    int hi [2][HIST];

    function automatic int lat(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int rows(input int d);
        return (d == 0) ? ROWS_A : ROWS_B;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_ph[d] = 0; m_row[d] = 0; m_it[d] = 0; m_itn[d] = 1; m_dat[d] = 0; m_done[d] = 1'b0;
        for (int k = 0; k < HIST; k++) hv[d][k] = 1'b0;
    endtask

    task automatic model_edge(input int d, input bit st, input int its, input bit hd, input bit ab);
        int s;
        s = cyc % HIST;
        hv[d][s]  = 1'b0;
        m_done[d] = 1'b0;
        if (ab) begin
            m_ph[d] = 0;
            for (int k = 0; k < HIST; k++) hv[d][k] = 1'b0;
        end else begin
            case (m_ph[d])
                0: if (st) begin
                    m_ph[d] = 1; m_row[d] = 0; m_it[d] = 0;
                    m_itn[d] = (its == 0) ? 1 : its;
                end
                1: if (!hd) begin
                    hv[d][s] = 1'b1; hr[d][s] = m_row[d]; hi[d][s] = m_it[d];
                    if (m_row[d] == rows(d) - 1 && m_it[d] == m_itn[d] - 1) begin
                        m_ph[d]  = 2;
                        m_dat[d] = cyc + lat(d) + 2;
                    end
                    m_row[d]++;
                    if (m_row[d] == rows(d)) begin
                        m_row[d] = 0;
                        m_it[d]++;
                    end
                end
                2: if (cyc == m_dat[d]) begin
                    m_ph[d] = 3; m_done[d] = 1'b1;
                end
                default: m_ph[d] = 0;
            endcase
        end
    endtask

    task automatic check_dut(input int d);
        int s, sc, sr;
        string p;
        logic b, dn, re, ce, rv;
        logic [3:0] ra, rr;
        logic [4:0] ri;
        if (d == 0) begin
            p = "A."; b = ifa.busy; dn = ifa.done; re = ifa.rd_en; ra = ifa.rd_addr;
            ce = ifa.cmp_en; rv = ifa.res_valid; rr = ifa.res_row; ri = ifa.res_iter;
        end else begin
            p = "B."; b = ifb.busy; dn = ifb.done; re = ifb.rd_en; ra = ifb.rd_addr;
            ce = ifb.cmp_en; rv = ifb.res_valid; rr = ifb.res_row; ri = ifb.res_iter;
        end
        s  = cyc % HIST;
        sc = (cyc - lat(d)) % HIST;
        sr = (cyc - lat(d) - 1) % HIST;
        chk({p, "busy"},      int'(b),  int'(m_ph[d] == 1 || m_ph[d] == 2));
        chk({p, "done"},      int'(dn), int'(m_done[d]));
        chk({p, "rd_en"},     int'(re), int'(hv[d][s]));
        if (hv[d][s]) chk({p, "rd_addr"}, int'(ra), hr[d][s]);
        chk({p, "cmp_en"},    int'(ce), int'(hv[d][sc]));
        chk({p, "res_valid"}, int'(rv), int'(hv[d][sr]));
        if (hv[d][sr]) begin
            chk({p, "res_row"},  int'(rr), hr[d][sr]);
            chk({p, "res_iter"}, int'(ri), hi[d][sr]);
        end
    endtask

    // Drive one cycle of inputs to both instances, advance one edge, check both
    task automatic step(input bit st, input int its, input bit hd, input bit ab, input bit rs);
        rst       = rs;
        ifa.start = st; ifa.iters = 5'(its); ifa.hold = hd; ifa.abort = ab;
        ifb.start = st; ifb.iters = 5'(its); ifb.hold = hd; ifb.abort = ab;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rs) model_reset(d);
            else    model_edge(d, st, its, hd, ab);
            check_dut(d);
        end
    endtask

    // Per-cycle masked stimulus on both instances; tallies instance A activity
    task automatic run_seq(input logic [31:0] smask, input logic [31:0] hmask,
                           input logic [31:0] amask, input int its, input int ncyc,
                           output int nrd, output int nres, output int ndone, output int dcyc);
        nrd = 0; nres = 0; ndone = 0; dcyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            step(smask[c], its, hmask[c], amask[c], 1'b0);
            if (ifa.rd_en)     nrd++;
            if (ifa.res_valid) nres++;
            if (ifa.done) begin ndone++; dcyc = c; end
        end
    endtask

    typedef struct {
        bit       start;
        int       iters;
        bit       busy;
        bit       rd_en;
        bit [3:0] addr;
        bit       cmp_en;
        bit       res_valid;
        bit [3:0] res_row;
        bit [4:0] res_iter;
        bit       done;
    } tv_t;

    tv_t tv [14];

    initial begin
        int nrd, nres, ndone, dcyc;

        // Nominal ROWS=4, RD_LAT=1, iters=2 run, start driven in c0
        for (int c = 0; c < 14; c++) begin
            tv[c].start     = (c == 0);
            tv[c].iters     = 2;
            tv[c].busy      = (c <= 10);
            tv[c].rd_en     = (c >= 1 && c <= 8);
            tv[c].addr      = 4'((c + 3) % 4);
            tv[c].cmp_en    = (c >= 2 && c <= 9);
            tv[c].res_valid = (c >= 3 && c <= 10);
            tv[c].res_row   = 4'((c + 1) % 4);
            tv[c].res_iter  = (c >= 7) ? 5'd1 : 5'd0;
            tv[c].done      = (c == 11);
        end

        ifa.start = 0; ifa.iters = 0; ifa.hold = 0; ifa.abort = 0;
        ifb.start = 0; ifb.iters = 0; ifb.hold = 0; ifb.abort = 0;
        model_reset(0); model_reset(1);

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Table-driven nominal run
        for (int c = 0; c < 14; c++) begin
            step(tv[c].start, tv[c].iters, 1'b0, 1'b0, 1'b0);
            chk("tbl.busy",   int'(ifa.busy),      int'(tv[c].busy));
            chk("tbl.rd_en",  int'(ifa.rd_en),     int'(tv[c].rd_en));
            if (tv[c].rd_en) chk("tbl.rd_addr", int'(ifa.rd_addr), int'(tv[c].addr));
            chk("tbl.cmp_en", int'(ifa.cmp_en),    int'(tv[c].cmp_en));
            chk("tbl.res_valid", int'(ifa.res_valid), int'(tv[c].res_valid));
            if (tv[c].res_valid) begin
                chk("tbl.res_row",  int'(ifa.res_row),  int'(tv[c].res_row));
                chk("tbl.res_iter", int'(ifa.res_iter), int'(tv[c].res_iter));
            end
            chk("tbl.done",   int'(ifa.done),      int'(tv[c].done));
        end

        // hold in c3..c4: rd_en gap, all 8 results, done slips to c13
        run_seq(32'h1, 32'h18, 32'h0, 2, 20, nrd, nres, ndone, dcyc);
        chk("hold.nrd", nrd, 8); chk("hold.nres", nres, 8);
        chk("hold.ndone", ndone, 1); chk("hold.dcyc", dcyc, 13);

        // start re-pulsed at c5 while busy is ignored
        run_seq(32'h21, 32'h0, 32'h0, 2, 20, nrd, nres, ndone, dcyc);
        chk("restart.nres", nres, 8); chk("restart.ndone", ndone, 1);
        chk("restart.dcyc", dcyc, 11);

        // abort at c5 kills the run: 4 reads, 2 results, no done
        run_seq(32'h1, 32'h0, 32'h20, 2, 20, nrd, nres, ndone, dcyc);
        chk("abort.nrd", nrd, 4); chk("abort.nres", nres, 2);
        chk("abort.ndone", ndone, 0);
        chk("abort.busy", int'(ifa.busy), 0);

        // abort and start together in IDLE: abort wins
        step(1'b1, 2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2, 1'b0, 1'b0, 1'b0);
        chk("abort_start.busy", int'(ifa.busy), 0);

        // iters=0 behaves as a single pass
        run_seq(32'h1, 32'h0, 32'h0, 0, 12, nrd, nres, ndone, dcyc);
        chk("iters0.nrd", nrd, 4); chk("iters0.nres", nres, 4);
        chk("iters0.ndone", ndone, 1); chk("iters0.dcyc", dcyc, 7);

        // Async reset mid-RUN: outputs drop before the next edge
        step(1'b1, 3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 3, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst.A.busy",   int'(ifa.busy),      0);
        chk("arst.A.rd_en",  int'(ifa.rd_en),     0);
        chk("arst.A.cmp_en", int'(ifa.cmp_en),    0);
        chk("arst.A.res",    int'(ifa.res_valid), 0);
        chk("arst.B.busy",   int'(ifb.busy),      0);
        chk("arst.B.rd_en",  int'(ifb.rd_en),     0);
        for (int i = 0; i < 2; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Rerun after reset: RD_LAT=3, ROWS=5 instance, one pass
        for (int c = 0; c < 14; c++) begin
            step(c == 0, 1, 1'b0, 1'b0, 1'b0);
            chk("lat3.rd_en",  int'(ifb.rd_en),     int'(c >= 1 && c <= 5));
            chk("lat3.cmp_en", int'(ifb.cmp_en),    int'(c >= 4 && c <= 8));
            chk("lat3.res",    int'(ifb.res_valid), int'(c >= 5 && c <= 9));
            chk("lat3.done",   int'(ifb.done),      int'(c == 10));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) == 0, int'($urandom % 4), ($urandom % 4) == 0,
                 ($urandom % 80) == 0, ($urandom % 300) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
